// File: rtl/pipe_stage_reg.sv
// Generic handshaked pipeline stage register with an optional one-entry skid buffer,
// bubble insertion on flush and a saturating count of entries discarded by flush.
module pipe_stage_reg #(
    parameter int unsigned          DATA_W     = 96,
    parameter logic [DATA_W-1:0]    BUBBLE_VAL = '0,
    parameter bit                   SKID_EN    = 1'b1,
    parameter int unsigned          CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Bit 1 of the encoding is the skid-valid flag, bit 0 is main-valid.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W:0]      cnt_sum;
    logic                skid_valid;
    logic                push;
    logic                pop;

    assign skid_valid = state_q[1];
    assign out_valid  = (state_q != S_EMPTY);
    assign out_data   = main_q;
    assign flush_cnt  = cnt_q;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            S_ONE:   occupancy = 2'd1;
            S_FULL:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        if (SKID_EN)
            in_ready = ~skid_valid & ~hold & ~flush & rst;
        else
            in_ready = ~hold & ~flush & rst & (~out_valid | out_ready);
    end

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready & ~hold;

    assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(occupancy);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
            cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_d = S_ONE;
                        main_d  = in_data;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push && SKID_EN) begin
                        state_d = S_FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register that replaces the fixed per-stage IF/ID, ID/EX, EX/MEM and MEM/WB registers with one generic block. It carries an opaque payload bus (PC, instruction, operands, control fields packed by the instantiating stage) with valid/ready flow control. An optional one-entry skid buffer gives full throughput with a registered ready. Flush inserts a configurable bubble payload, and the block counts discarded entries for performance analysis.

## Interface
- DATA_W, 96: payload width in bits (≥1).
- BUBBLE_VAL, {DATA_W{1'b0}}: payload presented whenever out_valid=0. The instantiating stage places 32'h00000013 in its instruction field.
- SKID_EN, 1: 1 = two-entry (main + skid) mode; 0 = single-register mode.
- CNT_W, 8: width of flush_cnt.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the next rising clk edge).
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a live entry.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_W  payload to next stage.
- hold  in  1  stall from hazard unit; freezes the stage.
- flush  in  1  discard all held entries; highest priority after reset.
- occupancy  out  2  live entries held (0..2; max 1 when SKID_EN=0).
- flush_cnt  out  CNT_W  saturating count of live entries discarded by flush.

## Operation
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready & ~hold.
- States: EMPTY (main invalid), ONE (main valid, skid invalid), FULL (main and skid valid; SKID_EN=1 only).
- Transitions in SKID_EN=1 mode:
  - EMPTY: push → ONE, main←in_data.
  - ONE: push&pop → ONE, main←in_data. push&~pop → FULL, skid←in_data. pop&~push → EMPTY. Otherwise stay.
  - FULL: pop → ONE, main←skid. Otherwise stay. No push is possible in FULL.
- Transitions in SKID_EN=0 mode:
  - EMPTY: push → ONE.
  - ONE: push (with pop) → ONE, main←in_data. pop only → EMPTY.
- in_ready:
  - SKID_EN=1: ~skid_valid & ~hold & ~flush & rst. The only dependence on state is the skid_valid flop.
  - SKID_EN=0: ~hold & ~flush & rst & (~out_valid | out_ready).
- hold=1: no push, no pop. All state, data and outputs remain unchanged.
- flush=1 (rst=1): next state EMPTY, skid cleared, out_data←BUBBLE_VAL. in_ready=0 that cycle, so no beat is lost. flush_cnt += occupancy, saturating at 2^CNT_W−1. flush overrides hold.
- out_data = main register. On every transition into EMPTY (pop, flush or reset) the main register is loaded with BUBBLE_VAL.
- occupancy: EMPTY=0, ONE=1, FULL=2.
- Payload is never modified. Entries leave in arrival order.

## Timing
- Reset values (rst=0 at clk edge): out_valid=0, out_data=BUBBLE_VAL, occupancy=0, flush_cnt=0, skid invalid. in_ready=0 while rst=0.
- Latency: push at edge N gives out_valid=1 with that data from edge N+1 (from EMPTY, or from ONE with a simultaneous pop).
- Throughput: one beat per cycle sustained in both modes while out_ready=1.
- SKID_EN=1: after out_ready drops, one extra beat is absorbed into the skid, then in_ready=0 on the following cycle. Recovery after out_ready returns: in_ready=1 one cycle after the skid drains.
- Simultaneous events:
  - flush with push or pop: flush wins; neither counts as a transfer.
  - hold with out_ready=1: no pop.
  - rst=0 with flush: reset wins and flush_cnt is not incremented.
- Reset or flush mid-stream: all held entries are dropped in one cycle. The next push is accepted on the cycle after rst/flush deasserts.
- No combinational path from in_data to out_data.

## Test plan
- Reset: rst=0 for 2 cycles with in_valid=1, in_data=0xAAA → out_valid=0, out_data=BUBBLE_VAL, in_ready=0, occupancy=0, flush_cnt=0.
- Streaming: SKID_EN=1, out_ready=1, push 1,2,3,4 on consecutive cycles → out_data 1,2,3,4 on consecutive cycles, each one cycle after its push, with in_ready held at 1.
- Backpressure: push 0x10,0x11,0x12 with out_ready=0 from the second cycle → occupancy=2, in_ready=0, 0x12 not accepted. Raise out_ready → 0x10 then 0x11 emerge in order, then 0x12 is accepted.
- Flush count: FULL with 0x20 and 0x21, flush=1 with in_valid=1 → next cycle out_valid=0, out_data=BUBBLE_VAL, flush_cnt=2, input not accepted. Repeat until flush_cnt saturates at 255 (CNT_W=8).
- Hold: ONE with 0x30, hold=1 for 3 cycles with out_ready=1 and in_valid=1 → out_data stays 0x30, in_ready=0, occupancy=1. After release, 0x30 pops and the new beat follows.
- SKID_EN=0: out_ready=0 while ONE → in_ready=0. out_ready=1 with in_valid=1 → replace-in-place, occupancy stays 1, never reaches 2.
